// File: rtl/usb3_pkg.sv
// Shared state encoding and frame geometry for the usb3 capture path
// and the display-side reader.
package usb3_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        PAYLOAD,
        DONE
    } state_t;

    localparam logic [31:0] DEF_SYNC_WORD       = 32'hA5A5_5A5A;
    localparam int          DEF_WORDS_PER_LINE  = 320;
    localparam int          DEF_LINES_PER_FRAME = 1024;
    localparam int          DEF_TIMEOUT_CYCLES  = 65535;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb3_frame_counter.sv
// Word/line position within a frame plus line, frame and last-word decode.
// Holds on the final word so the line index stays visible until the next clear.
module usb3_frame_counter
    import usb3_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clear,
    input  logic                              advance,
    output logic [cnt_w(LINES_PER_FRAME)-1:0] line_ctr,
    output logic                              last_word,
    output logic                              line_first,
    output logic                              frame_first
);

    localparam int WW = cnt_w(WORDS_PER_LINE);
    localparam int LW = cnt_w(LINES_PER_FRAME);
    localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_LINE - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LINES_PER_FRAME - 1);
    localparam logic [WW-1:0] W_ONE  = WW'(1);
    localparam logic [LW-1:0] L_ONE  = LW'(1);

    logic [WW-1:0] word_ctr;
    logic          word_last;

    assign word_last   = (word_ctr == W_LAST);
    assign last_word   = word_last && (line_ctr == L_LAST);
    assign line_first  = (word_ctr == '0);
    assign frame_first = line_first && (line_ctr == '0);

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            word_ctr <= '0;
            line_ctr <= '0;
        end else if (advance && !last_word) begin
            if (word_last) begin
                word_ctr <= '0;
                line_ctr <= line_ctr + L_ONE;
            end else begin
                word_ctr <= word_ctr + W_ONE;
            end
        end
    end

endmodule

// File: rtl/usb3_frame_ctrl.sv
// Frame sequencer between usb3_if and the dc32 FIFO: finds the sync word,
// forwards one frame of payload and reports framing, completion and timeouts.
module usb3_frame_ctrl
    import usb3_pkg::*;
#(
    parameter int          WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int          LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter logic [31:0] SYNC_WORD       = DEF_SYNC_WORD,
    parameter int          TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                              ftdi_clk,
    input  logic                              reset_n,
    input  logic                              arm,
    output logic                              usb3_rx_enable,
    input  logic                              write_to_dc32_fifo,
    input  logic [31:0]                       dc32_fifo_data_in,
    input  logic                              dc_fifo_almost_full,
    output logic                              fifo_wr_en,
    output logic [31:0]                       fifo_wr_data,
    output logic                              frame_start,
    output logic                              line_start,
    output logic                              frame_done,
    output logic                              sync_error,
    output logic [cnt_w(LINES_PER_FRAME)-1:0] line_count,
    output logic [15:0]                       frame_count
);

    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] idle_ctr;
    logic [TW-1:0] idle_nx;
    logic          sync_hit;
    logic          fwd;
    logic          adv;
    logic          clr;
    logic          tmo;
    logic          last_word;
    logic          line_first;
    logic          frame_first;

    usb3_frame_counter #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME)
    ) u_counter (
        .clk        (ftdi_clk),
        .reset_n    (reset_n),
        .clear      (clr),
        .advance    (adv),
        .line_ctr   (line_count),
        .last_word  (last_word),
        .line_first (line_first),
        .frame_first(frame_first)
    );

    assign sync_hit = write_to_dc32_fifo && (dc32_fifo_data_in == SYNC_WORD);

    always_comb begin
        state_nx = state;
        idle_nx  = '0;
        fwd      = 1'b0;
        adv      = 1'b0;
        clr      = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm) state_nx = HUNT;
            end
            // a word landing in DONE is judged exactly as in HUNT
            HUNT, DONE: begin
                if (!arm) begin
                    state_nx = IDLE;
                end else if (sync_hit) begin
                    state_nx = PAYLOAD;
                    clr      = 1'b1;
                end else begin
                    state_nx = HUNT;
                end
            end
            PAYLOAD: begin
                if (write_to_dc32_fifo) begin
                    fwd = 1'b1;
                    adv = 1'b1;
                    if (last_word) state_nx = DONE;
                end else if (usb3_rx_enable) begin
                    if (idle_ctr == T_LAST) begin
                        tmo      = 1'b1;
                        clr      = 1'b1;
                        state_nx = arm ? HUNT : IDLE;
                    end else begin
                        idle_nx = idle_ctr + T_ONE;
                    end
                end else begin
                    idle_nx = idle_ctr;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ftdi_clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            idle_ctr       <= '0;
            usb3_rx_enable <= 1'b0;
            fifo_wr_en     <= 1'b0;
            fifo_wr_data   <= '0;
            frame_start    <= 1'b0;
            line_start     <= 1'b0;
            frame_done     <= 1'b0;
            sync_error     <= 1'b0;
            frame_count    <= '0;
        end else begin
            state          <= state_nx;
            idle_ctr       <= idle_nx;
            usb3_rx_enable <= (state_nx != IDLE) && !dc_fifo_almost_full;
            fifo_wr_en     <= fwd;
            if (fwd) fifo_wr_data <= dc32_fifo_data_in;
            frame_start    <= fwd && frame_first;
            line_start     <= fwd && line_first;
            frame_done     <= (state == DONE);
            sync_error     <= tmo;
            if (state == DONE) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_usb3_frame_ctrl.sv
// Directed bench for usb3_frame_ctrl with a 4-word, 2-line frame
// and an 8-cycle idle timeout.
module tb_usb3_frame_ctrl;

    localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

    logic        ftdi_clk = 1'b0;
    logic        reset_n;
    logic        arm;
    logic        strobe;
    logic [31:0] din;
    logic        af;
    logic        rx_en;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        frame_start;
    logic        line_start;
    logic        frame_done;
    logic        sync_error;
    logic [0:0]  line_count;
    logic [15:0] frame_count;

    usb3_frame_ctrl #(
        .WORDS_PER_LINE (4),
        .LINES_PER_FRAME(2),
        .SYNC_WORD      (SYNC),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ftdi_clk           (ftdi_clk),
        .reset_n            (reset_n),
        .arm                (arm),
        .usb3_rx_enable     (rx_en),
        .write_to_dc32_fifo (strobe),
        .dc32_fifo_data_in  (din),
        .dc_fifo_almost_full(af),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_wr_data       (fifo_wr_data),
        .frame_start        (frame_start),
        .line_start         (line_start),
        .frame_done         (frame_done),
        .sync_error         (sync_error),
        .line_count         (line_count),
        .frame_count        (frame_count)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    int errs = 0;
    int checks = 0;

    logic [31:0] wr_log[$];
    int          ls_idx[$];
    int          fs_idx[$];
    int          n_fd;
    int          n_se;
    int          n_stray;

    always @(negedge ftdi_clk) begin
        if (fifo_wr_en) begin
            wr_log.push_back(fifo_wr_data);
            if (line_start) ls_idx.push_back(wr_log.size());
            if (frame_start) fs_idx.push_back(wr_log.size());
        end else if (line_start || frame_start) begin
            n_stray++;
        end
        if (frame_done) n_fd++;
        if (sync_error) n_se++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ftdi_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        strobe = 1'b1;
        din    = w;
        tick(1);
        strobe = 1'b0;
        din    = '0;
    endtask

    task automatic clear_mon();
        wr_log.delete();
        ls_idx.delete();
        fs_idx.delete();
        n_fd    = 0;
        n_se    = 0;
        n_stray = 0;
    endtask

    task automatic check_log(input string tag, input logic [31:0] exp[$]);
        check({tag, "_count"}, wr_log.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i),
                  (i < wr_log.size()) ? wr_log[i] : 32'hxxxx_xxxx, exp[i]);
        end
    endtask

    logic [31:0] seq8[$];
    logic [31:0] seq_s[$];

    initial begin
        reset_n = 1'b0;
        arm     = 1'b0;
        strobe  = 1'b0;
        din     = '0;
        af      = 1'b0;
        n_fd    = 0;
        n_se    = 0;
        n_stray = 0;
        seq8    = '{1, 2, 3, 4, 5, 6, 7, 8};
        seq_s   = '{1, 2, SYNC, 4, 5, 6, 7, 8};

        tick(2);
        check("rst_rx_en", rx_en, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", fifo_wr_data, 0);
        check("rst_flags", {frame_start, line_start, frame_done, sync_error}, 0);
        check("rst_lines", line_count, 0);
        check("rst_frames", frame_count, 0);

        // 1: junk, sync, one clean frame
        reset_n = 1'b1;
        arm     = 1'b1;
        tick(1);
        check("t1_rx_en_on", rx_en, 1);
        clear_mon();
        send(32'h1111_0000);
        send(32'hDEAD_BEEF);
        send(32'hA5A5_5A5B);
        send(SYNC);
        check("t1_sync_not_written", fifo_wr_en, 0);
        send(1);
        check("t1_w1_wr", fifo_wr_en, 1);
        check("t1_w1_data", fifo_wr_data, 1);
        check("t1_w1_fs", frame_start, 1);
        check("t1_w1_ls", line_start, 1);
        for (int i = 2; i <= 7; i++) send(i);
        send(8);
        check("t1_w8_data", fifo_wr_data, 8);
        check("t1_w8_no_fd", frame_done, 0);
        tick(1);
        check("t1_fd", frame_done, 1);
        check("t1_frames", frame_count, 1);
        check("t1_wr_off", fifo_wr_en, 0);
        check("t1_lines_hold", line_count, 1);
        tick(1);
        check("t1_fd_pulse", frame_done, 0);
        check_log("t1_log", seq8);
        check("t1_ls_n", ls_idx.size(), 2);
        check("t1_ls0", (ls_idx.size() > 0) ? ls_idx[0] : -1, 1);
        check("t1_ls1", (ls_idx.size() > 1) ? ls_idx[1] : -1, 5);
        check("t1_fs_n", fs_idx.size(), 1);
        check("t1_fs0", (fs_idx.size() > 0) ? fs_idx[0] : -1, 1);
        check("t1_stray", n_stray, 0);
        check("t1_fd_n", n_fd, 1);

        // 2: sync pattern inside payload is data
        clear_mon();
        send(SYNC);
        foreach (seq_s[i]) send(seq_s[i]);
        tick(2);
        check_log("t2_log", seq_s);
        check("t2_fd_n", n_fd, 1);
        check("t2_ls_n", ls_idx.size(), 2);
        check("t2_frames", frame_count, 2);

        // 3: idle timeout aborts, next frame is clean
        clear_mon();
        send(SYNC);
        send(1);
        send(2);
        send(3);
        check("t3_lines_mid", line_count, 0);
        tick(7);
        check("t3_no_se_early", sync_error, 0);
        tick(1);
        check("t3_se", sync_error, 1);
        check("t3_frames_same", frame_count, 2);
        check("t3_rx_hunt", rx_en, 1);
        tick(1);
        check("t3_se_pulse", sync_error, 0);
        check("t3_fd_n", n_fd, 0);
        check("t3_se_n", n_se, 1);
        clear_mon();
        send(SYNC);
        foreach (seq8[i]) send(seq8[i]);
        tick(2);
        check_log("t3_log", seq8);
        check("t3_frames", frame_count, 3);

        // 4: almost-full throttle mid-frame
        clear_mon();
        send(SYNC);
        send(1);
        send(2);
        send(3);
        af = 1'b1;
        tick(1);
        check("t4_rx_off", rx_en, 0);
        tick(5);
        send(4);
        check("t4_w4_wr", fifo_wr_en, 1);
        check("t4_w4_data", fifo_wr_data, 4);
        tick(5);
        send(5);
        tick(7);
        check("t4_rx_still_off", rx_en, 0);
        af = 1'b0;
        tick(1);
        check("t4_rx_on", rx_en, 1);
        send(6);
        send(7);
        send(8);
        tick(2);
        check_log("t4_log", seq8);
        check("t4_se_n", n_se, 0);
        check("t4_fd_n", n_fd, 1);
        check("t4_frames", frame_count, 4);

        // 5: disarm mid-frame, frame still finishes, then idle
        clear_mon();
        send(SYNC);
        for (int i = 1; i <= 4; i++) send(i);
        arm = 1'b0;
        for (int i = 5; i <= 8; i++) send(i);
        check("t5_rx_in_done", rx_en, 1);
        tick(1);
        check("t5_fd", frame_done, 1);
        check("t5_rx_idle", rx_en, 0);
        send(SYNC);
        send(32'h0000_00AA);
        send(32'h0000_00BB);
        tick(2);
        check_log("t5_log", seq8);
        check("t5_frames", frame_count, 5);

        // 6: reset in the middle of a frame
        arm = 1'b1;
        tick(1);
        clear_mon();
        send(SYNC);
        for (int i = 1; i <= 5; i++) send(i);
        reset_n = 1'b0;
        send(6);
        reset_n = 1'b1;
        check("t6_wr_off", fifo_wr_en, 0);
        check("t6_rx_off", rx_en, 0);
        check("t6_frames_clr", frame_count, 0);
        check("t6_lines_clr", line_count, 0);
        send(7);
        send(8);
        tick(3);
        check("t6_discard_n", wr_log.size(), 5);
        check("t6_fd_n", n_fd, 0);
        check("t6_se_n", n_se, 0);
        clear_mon();
        send(SYNC);
        foreach (seq8[i]) send(seq8[i]);
        tick(2);
        check_log("t6_log", seq8);
        check("t6_frames", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
